apb_v3_master: RTL and testbench
================================

Name: apb_v3_master

Overview:
APB v3 initiator (requester). It is the opposite end of the team's APB SRAM responder.
- Accepts single read/write commands on a valid/ready command port.
- Runs the IDLE -> SETUP -> ACCESS APB sequence, honouring P_ready wait states and P_slverr.
- Returns read data and error status on a one-cycle response strobe.
- Sits between a CPU/DMA-side request source and an APB slave such as the SRAM block.

Parameters:
- ADDR_W, 32, width of cmd_addr and P_addr.
- DATA_W, 32, width of write/read data paths.
- TIMEOUT_CYCLES, 16, ACCESS wait-state limit. Used only when APB_MASTER_TIMEOUT_EN is defined; must be >= 1.

Ports:
- P_clk  input  1  clock; all logic on the rising edge.
- P_rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at the rising edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  transfer address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  slave error or timeout for the completed transfer.
- P_addr  output  ADDR_W  APB address.
- P_selx  output  1  APB select.
- P_enable  output  1  APB enable.
- P_write  output  1  APB direction.
- P_wdata  output  DATA_W  APB write data.
- P_ready  input  1  slave ready.
- P_rdata  input  DATA_W  slave read data.
- P_slverr  input  1  slave error; sampled only with P_ready in ACCESS.

Behaviour:
- Reset (P_rst_n low, async): state = IDLE. All outputs are 0 (P_selx, P_enable, P_write, P_addr, P_wdata, rsp_valid, rsp_rdata, rsp_err). cmd_ready is 0 while reset is asserted, then 1 in IDLE.
- Reset mid-transfer: the transfer is abandoned and no rsp_valid is issued. After release the block is in IDLE.
- States (2-bit): IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
- cmd_ready is combinational: 1 when state == IDLE, or when state == ACCESS && P_ready == 1. Otherwise 0.
- On accept: register cmd_addr/cmd_write/cmd_wdata into P_addr/P_write/P_wdata; next state = SETUP.
  - P_wdata is updated only for writes and keeps its previous value for reads.
- IDLE: P_selx = 0, P_enable = 0. P_addr/P_write/P_wdata hold their last values.
- SETUP: P_selx = 1, P_enable = 0 for exactly one cycle, then ACCESS unconditionally.
- ACCESS: P_selx = 1, P_enable = 1. P_addr/P_write/P_wdata are stable until completion.
  - P_ready = 0: remain in ACCESS.
  - P_ready = 1 with a new command accepted in the same cycle: go to SETUP. This is the back-to-back case: P_selx stays 1 and P_enable drops to 0.
  - P_ready = 1 with no command: go to IDLE.
- Completion (ACCESS && P_ready): on the next cycle rsp_valid = 1 for exactly one cycle.
  - rsp_rdata = P_rdata sampled at completion for reads, 0 for writes.
  - rsp_err = P_slverr sampled at completion.
  - rsp_rdata and rsp_err hold their values until the next completion.
- Latency, zero-wait: accept at edge N -> SETUP during cycle N+1 -> ACCESS during cycle N+2 -> rsp_valid during cycle N+3. Each wait state adds 1 cycle.
- Back-to-back throughput: one transfer per 2 cycles with zero waits.
- There is no response back-pressure; the consumer must accept rsp_valid whenever it pulses.
- cmd_* inputs are ignored while cmd_ready = 0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on every ACCESS cycle with P_ready = 0.
  - When the count reaches TIMEOUT_CYCLES with P_ready still 0, the transfer is aborted: next state IDLE, P_selx = 0, P_enable = 0.
  - The next cycle has rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - cmd_ready is 0 during the abort cycle.
  - If P_ready = 1 in the same cycle the limit is reached, the transfer completes normally; P_ready wins.
- Undefined: no counter. ACCESS waits indefinitely, and rsp_err reflects only P_slverr.

Decomposition:
- Package apb_v3_pkg:
  - state typedef and constants IDLE/SETUP/ACCESS;
  - default ADDR_W/DATA_W;
  - RSP_ERR_TIMEOUT reason constant.
- One natural sub-module, apb_v3_wait_counter: clear/increment counter with a limit flag, instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0xA5A5_0001 to addr 0x04, P_ready tied 1 -> SETUP at N+1 (P_selx=1, P_enable=0); ACCESS at N+2 with P_addr=0x04, P_write=1, P_wdata=0xA5A5_0001; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read 0x04, P_ready low for 3 ACCESS cycles, P_rdata=0x0000_00A5 at completion -> P_addr/P_write stable through 4 ACCESS cycles; rsp_valid at N+6 with rsp_rdata=0x0000_00A5.
- cmd_valid held high with writes to 0x00, 0x01, 0x02, zero-wait -> P_selx never drops between transfers; P_enable pattern 0,1,0,1,0,1; three rsp_valid pulses 2 cycles apart.
- Read with P_slverr=1 at completion -> rsp_err=1, then next transfer rsp_err=0.
- Assert P_rst_n low during ACCESS (P_ready=0) -> all outputs 0 immediately (async), no rsp_valid; after release a read of 0x08 completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, P_ready held 0 -> abort after 4 wait cycles, rsp_valid=1, rsp_err=1, P_selx=0; without the macro the master is still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_v3_pkg.sv
// Shared types and constants for the APB v3 master and its wait counter.
package apb_v3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // rsp_err value reported when a transfer is aborted by the wait-state limit
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/apb_v3_wait_counter.sv
// ACCESS wait-state counter: clears on entry to ACCESS, counts P_ready-low cycles,
// and flags the cycle that would be the LIMIT-th wait.
module apb_v3_wait_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  assign o_limit = (r_count == CW'(LIMIT - 1));

  // Saturates at LIMIT-1; the master aborts on that cycle so no further counting matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_v3_master.sv
// APB v3 initiator: valid/ready command in, IDLE->SETUP->ACCESS on the bus, one-cycle response out.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_v3_master
  import apb_v3_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              P_clk,
  input  logic              P_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic [DATA_W-1:0] P_rdata,
  input  logic              P_slverr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_v3_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_selx;
  logic              r_enable;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_done;
  logic w_accept;
  logic w_timeout;

  assign w_done    = (r_state == ACCESS) && P_ready;
  assign cmd_ready = P_rst_n && ((r_state == IDLE) || w_done);
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_limit;

  apb_v3_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk     (P_clk),
    .rst_n   (P_rst_n),
    .i_clear (r_state == SETUP),
    .i_inc   ((r_state == ACCESS) && !P_ready),
    .o_limit (w_limit)
  );

  assign w_timeout = (r_state == ACCESS) && !P_ready && w_limit;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_selx      <= 1'b0;
      r_enable    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      // Reads leave P_wdata at its last written value.
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_write <= cmd_write;
        if (cmd_write) begin
          r_wdata <= cmd_wdata;
        end
      end

      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_write ? '0 : P_rdata;
        r_rsp_err   <= P_slverr;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_err   <= RSP_ERR_TIMEOUT;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= SETUP;
            r_selx   <= 1'b1;
            r_enable <= 1'b0;
          end
        end
        SETUP: begin
          r_state  <= ACCESS;
          r_selx   <= 1'b1;
          r_enable <= 1'b1;
        end
        ACCESS: begin
          if (w_done) begin
            // Back-to-back: keep P_selx high and re-enter SETUP.
            if (w_accept) begin
              r_state  <= SETUP;
              r_selx   <= 1'b1;
              r_enable <= 1'b0;
            end else begin
              r_state  <= IDLE;
              r_selx   <= 1'b0;
              r_enable <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state  <= IDLE;
            r_selx   <= 1'b0;
            r_enable <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_selx   <= 1'b0;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

  assign P_addr    = r_addr;
  assign P_write   = r_write;
  assign P_wdata   = r_wdata;
  assign P_selx    = r_selx;
  assign P_enable  = r_enable;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_v3_master.sv
// Directed bench for apb_v3_master with a response scoreboard; APB slave driven from the bench.
module tb_apb_v3_master;

  logic        P_clk = 1'b0;
  logic        P_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] P_addr;
  logic        P_selx;
  logic        P_enable;
  logic        P_write;
  logic [31:0] P_wdata;
  logic        P_ready;
  logic [31:0] P_rdata;
  logic        P_slverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 P_clk = ~P_clk;

  apb_v3_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .P_clk     (P_clk),
    .P_rst_n   (P_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .P_addr    (P_addr),
    .P_selx    (P_selx),
    .P_enable  (P_enable),
    .P_write   (P_write),
    .P_wdata   (P_wdata),
    .P_ready   (P_ready),
    .P_rdata   (P_rdata),
    .P_slverr  (P_slverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge P_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge P_clk);
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Zero-wait single transfer with full SETUP/ACCESS/response timing checks.
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input logic se);
    P_ready  = 1'b1;
    P_rdata  = rd;
    P_slverr = se;
    step();
    drive_cmd(w, a, d);
    sb.push_back('{rdata: (w ? 32'h0 : rd), err: se});
    step();
    cmd_valid = 1'b0;
    at_neg();
    check("setup_selx", P_selx, 1);
    check("setup_enable", P_enable, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    step();
    at_neg();
    check("access_enable", P_enable, 1);
    check("access_addr", P_addr, a);
    check("access_write", P_write, w);
    if (w) check("access_wdata", P_wdata, d);
    check("access_cmd_ready", cmd_ready, 1);
    step();
    P_slverr = 1'b0;
    at_neg();
    check("rsp_strobe", rsp_valid, 1);
    check("idle_selx", P_selx, 0);
  endtask

  // Scoreboard consumer: every response strobe must match the oldest expected entry.
  always @(negedge P_clk) begin
    if (rsp_valid === 1'b1) begin
      check("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        $display("rsp t=%0t rdata=%08h err=%0d (exp rdata=%08h err=%0d)",
                 $time, rsp_rdata, rsp_err, e.rdata, e.err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    P_rst_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    P_ready   = 1'b1;
    P_rdata   = '0;
    P_slverr  = 1'b0;

    // Reset state
    at_neg();
    check("rst_selx", P_selx, 0);
    check("rst_enable", P_enable, 0);
    check("rst_write", P_write, 0);
    check("rst_addr", P_addr, 0);
    check("rst_wdata", P_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    step();
    P_rst_n = 1'b1;
    at_neg();
    check("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    do_xfer(1'b1, 32'h04, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0);
    check("wr_rsp_rdata_zero", rsp_rdata, 0);

    // Read with three wait states
    P_ready = 1'b0;
    P_rdata = 32'h0000_0BAD;
    step();
    drive_cmd(1'b0, 32'h04, 32'h1234_5678);
    sb.push_back('{rdata: 32'h0000_00A5, err: 1'b0});
    step();
    cmd_valid = 1'b0;
    at_neg();
    check("rd_setup_enable", P_enable, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) begin
        P_ready = 1'b1;
        P_rdata = 32'h0000_00A5;
      end
      at_neg();
      check("rd_wait_enable", P_enable, 1);
      check("rd_wait_addr", P_addr, 32'h04);
      check("rd_wait_write", P_write, 0);
      check("rd_wdata_kept", P_wdata, 32'hA5A5_0001);
      check("rd_wait_rsp_valid", rsp_valid, 0);
      check("rd_wait_cmd_ready", cmd_ready, (i == 3) ? 1 : 0);
    end
    step();
    at_neg();
    check("rd_rsp_strobe", rsp_valid, 1);

    // Back-to-back writes with cmd_valid held high
    P_ready = 1'b1;
    step();
    drive_cmd(1'b1, 32'h00, 32'h0000_0100);
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      step();
      if (k < 2) begin
        drive_cmd(1'b1, 32'(k + 1), 32'h0000_0100 + 32'(k + 1));
        sb.push_back('{rdata: 32'h0, err: 1'b0});
      end else begin
        cmd_valid = 1'b0;
      end
      at_neg();
      check("b2b_setup_selx", P_selx, 1);
      check("b2b_setup_enable", P_enable, 0);
      check("b2b_setup_rsp", rsp_valid, (k > 0) ? 1 : 0);
      step();
      at_neg();
      check("b2b_access_selx", P_selx, 1);
      check("b2b_access_enable", P_enable, 1);
      check("b2b_access_addr", P_addr, 32'(k));
      check("b2b_access_wdata", P_wdata, 32'h0000_0100 + 32'(k));
      check("b2b_access_rsp", rsp_valid, 0);
    end
    step();
    at_neg();
    check("b2b_last_rsp", rsp_valid, 1);
    check("b2b_idle_selx", P_selx, 0);

    // Slave error, hold, then clean transfer
    do_xfer(1'b0, 32'h10, 32'h0, 32'h0000_DEAD, 1'b1);
    step();
    at_neg();
    check("err_hold_valid", rsp_valid, 0);
    check("err_hold_err", rsp_err, 1);
    check("err_hold_rdata", rsp_rdata, 32'h0000_DEAD);
    do_xfer(1'b1, 32'h14, 32'h5555_AAAA, 32'h0, 1'b0);
    check("err_cleared", rsp_err, 0);

    // Asynchronous reset during ACCESS
    P_ready = 1'b0;
    step();
    drive_cmd(1'b0, 32'h20, 32'h0);
    step();
    cmd_valid = 1'b0;
    at_neg();
    step();
    at_neg();
    check("prerst_enable", P_enable, 1);
    #2;
    P_rst_n = 1'b0;
    #1;
    check("arst_selx", P_selx, 0);
    check("arst_enable", P_enable, 0);
    check("arst_addr", P_addr, 0);
    check("arst_write", P_write, 0);
    check("arst_wdata", P_wdata, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_rdata", rsp_rdata, 0);
    check("arst_rsp_err", rsp_err, 0);
    check("arst_cmd_ready", cmd_ready, 0);
    repeat (3) step();
    P_rst_n = 1'b1;
    at_neg();
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    do_xfer(1'b0, 32'h08, 32'h0, 32'h0000_0088, 1'b0);

    // Long stall: timeout abort when enabled, indefinite wait otherwise
    P_ready = 1'b0;
    P_rdata = 32'h0000_0077;
    step();
    drive_cmd(1'b0, 32'h30, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1});
`else
    sb.push_back('{rdata: 32'h0000_0077, err: 1'b0});
`endif
    step();
    cmd_valid = 1'b0;
    at_neg();
    check("stall_setup_enable", P_enable, 0);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      at_neg();
      check("to_wait_enable", P_enable, 1);
      check("to_wait_rsp", rsp_valid, 0);
    end
    step();
    at_neg();
    check("to_abort_selx", P_selx, 0);
    check("to_abort_enable", P_enable, 0);
    check("to_abort_rsp", rsp_valid, 1);
    check("to_abort_err", rsp_err, 1);
`else
    repeat (100) step();
    at_neg();
    check("stall_selx", P_selx, 1);
    check("stall_enable", P_enable, 1);
    check("stall_cmd_ready", cmd_ready, 0);
    P_ready = 1'b1;
    step();
    at_neg();
    check("stall_rsp", rsp_valid, 1);
`endif
    P_ready = 1'b1;

    repeat (2) step();
    at_neg();
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
